// File: rtl/alu_muldiv.sv
// alu_muldiv: RV32M multiply/divide unit with a pipelined multiplier and an iterative radix-2 divider.
module alu_muldiv #(
    parameter int XLEN      = 32,
    parameter int ROB_WIDTH = 4,
    parameter int MUL_LAT   = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 clear_signal,
    input  logic                 cal_signal,
    input  logic [2:0]           opcode,
    input  logic [XLEN-1:0]      lhs,
    input  logic [XLEN-1:0]      rhs,
    input  logic [ROB_WIDTH-1:0] tag,
    output logic                 mul_ready_out,
    output logic                 div_ready_out,
    output logic                 done_result,
    output logic [XLEN-1:0]      value_result,
    output logic [ROB_WIDTH-1:0] tag_result
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int CW = $clog2(XLEN + 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [XLEN-1:0]      quo, rem, dvs;
    logic                 quot_neg, rem_neg, want_rem;
    logic [ROB_WIDTH-1:0] div_tag;
    logic [MUL_LAT-1:0]   mul_v;
    logic [XLEN-1:0]      mul_val [MUL_LAT];
    logic [ROB_WIDTH-1:0] mul_tag [MUL_LAT];
    logic                 mul_acc, div_acc, lhs_neg, rhs_neg, div_zero, div_ovf;
    logic [2*XLEN-1:0]    ma, mb, prod;
    logic [XLEN-1:0]      mul_res, l_mag, r_mag, div_res;
    logic [XLEN:0]        shifted, diff;

    always_comb begin
        mul_ready_out = state == IDLE;
        div_ready_out = state == IDLE && mul_v == '0;
        mul_acc  = rdy_in && !clear_signal && cal_signal && !opcode[2] && mul_ready_out;
        div_acc  = rdy_in && !clear_signal && cal_signal && opcode[2] && div_ready_out;
        ma       = {{XLEN{(opcode == 3'd1 || opcode == 3'd2) && lhs[XLEN-1]}}, lhs};
        mb       = {{XLEN{opcode == 3'd1 && rhs[XLEN-1]}}, rhs};
        prod     = ma * mb;
        mul_res  = opcode[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        lhs_neg  = !opcode[0] && lhs[XLEN-1];
        rhs_neg  = !opcode[0] && rhs[XLEN-1];
        l_mag    = lhs_neg ? -lhs : lhs;
        r_mag    = rhs_neg ? -rhs : rhs;
        div_zero = rhs == '0;
        div_ovf  = !opcode[0] && lhs == {1'b1, {(XLEN-1){1'b0}}} && rhs == '1;
        shifted  = {rem, quo[XLEN-1]};
        diff     = shifted - {1'b0, dvs};
        div_res  = want_rem ? (rem_neg ? -rem : rem) : (quot_neg ? -quo : quo);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            cnt          <= '0;
            quo          <= '0;
            rem          <= '0;
            dvs          <= '0;
            quot_neg     <= 1'b0;
            rem_neg      <= 1'b0;
            want_rem     <= 1'b0;
            div_tag      <= '0;
            mul_v        <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                mul_val[i] <= '0;
                mul_tag[i] <= '0;
            end
            done_result  <= 1'b0;
            value_result <= '0;
            tag_result   <= '0;
        end else if (rdy_in) begin
            if (clear_signal) begin
                done_result <= 1'b0;
                mul_v       <= '0;
                state       <= IDLE;
            end else begin
                mul_v[0]   <= mul_acc;
                mul_val[0] <= mul_res;
                mul_tag[0] <= tag;
                for (int i = 1; i < MUL_LAT; i++) begin
                    mul_v[i]   <= mul_v[i-1];
                    mul_val[i] <= mul_val[i-1];
                    mul_tag[i] <= mul_tag[i-1];
                end
                // The two paths never finish together: divides wait for an empty multiplier pipe.
                done_result <= mul_v[MUL_LAT-1] || state == DONE;
                if (mul_v[MUL_LAT-1]) begin
                    value_result <= mul_val[MUL_LAT-1];
                    tag_result   <= mul_tag[MUL_LAT-1];
                end else if (state == DONE) begin
                    value_result <= div_res;
                    tag_result   <= div_tag;
                end
                if (state == IDLE && div_acc) begin
                    div_tag  <= tag;
                    want_rem <= opcode[1];
                    if (div_zero || div_ovf) begin
                        state    <= DONE;
                        quot_neg <= 1'b0;
                        rem_neg  <= 1'b0;
                        quo      <= div_zero ? '1 : lhs;
                        rem      <= div_zero ? lhs : '0;
                    end else begin
                        state    <= RUN;
                        cnt      <= CW'(XLEN);
                        quo      <= l_mag;
                        rem      <= '0;
                        dvs      <= r_mag;
                        quot_neg <= lhs_neg ^ rhs_neg;
                        rem_neg  <= lhs_neg;
                    end
                end else if (state == RUN) begin
                    rem <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], !diff[XLEN]};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= DONE;
                end else if (state == DONE) begin
                    state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed and random checks of alu_muldiv against a cycle-tagged result scoreboard.
module tb_alu_muldiv;
    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;

    typedef struct {
        logic [3:0]  t;
        logic [31:0] v;
        int          c;
    } exp_t;

    logic        clk_in, rst_n_in, rdy_in, clear_signal, cal_signal;
    logic [2:0]  opcode;
    logic [31:0] lhs, rhs, value_result;
    logic [3:0]  tag, tag_result;
    logic        mul_ready_out, div_ready_out, done_result;

    int   checks, errors, cyc;
    exp_t exp_q[$];
    exp_t e;
    logic r_edge;

    alu_muldiv #(.XLEN(XLEN), .ROB_WIDTH(4), .MUL_LAT(MUL_LAT)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
        .cal_signal(cal_signal), .opcode(opcode), .lhs(lhs), .rhs(rhs), .tag(tag),
        .mul_ready_out(mul_ready_out), .div_ready_out(div_ready_out), .done_result(done_result),
        .value_result(value_result), .tag_result(tag_result)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] ref_val(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: return b == 0 ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    // Records every rdy-qualified result pulse and matches it against the oldest expectation.
    always @(posedge clk_in) begin
        r_edge = rdy_in;
        cyc++;
        #1;
        if (r_edge && rst_n_in && done_result) begin
            if (exp_q.size() == 0) check("spurious_done", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("res_tag", tag_result, e.t);
                check("res_val", value_result, e.v);
                check("res_cycle", cyc, e.c);
            end
        end
    end

    always @(posedge clk_in)
        if (rst_n_in && rdy_in && cal_signal && !clear_signal)
            assert (opcode[2] ? div_ready_out : mul_ready_out) else $error("issue while unit not ready");

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t, input logic [31:0] want, output int acc);
        int   n;
        int   lat;
        exp_t x;
        n = 0;
        while (!(op[2] ? div_ready_out : mul_ready_out) && n < 200) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (n >= 200) begin
            check("issue_timeout", 1, 0);
            acc = -1;
            return;
        end
        opcode = op; lhs = a; rhs = b; tag = t; cal_signal = 1'b1;
        @(posedge clk_in); #1;
        cal_signal = 1'b0;
        acc = cyc;
        lat = !op[2] ? MUL_LAT :
              (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : XLEN + 1;
        x.t = t; x.v = want; x.c = acc + lat;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_in); #1; end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk_in); #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic stall(input int n);
        rdy_in = 1'b0;
        idle(n);
        rdy_in = 1'b1;
        foreach (exp_q[i]) exp_q[i].c += n;
    endtask

    task automatic flush();
        clear_signal = 1'b1;
        @(posedge clk_in); #1;
        clear_signal = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int acc, acc2, mode;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [3:0]  t;
        checks = 0; errors = 0; cyc = 0;
        rst_n_in = 1'b0; rdy_in = 1'b1; clear_signal = 1'b0; cal_signal = 1'b0;
        opcode = '0; lhs = '0; rhs = '0; tag = '0;
        #12;
        check("rst_done", done_result, 0);
        check("rst_value", value_result, 0);
        check("rst_tag", tag_result, 0);
        check("rst_ready", {mul_ready_out, div_ready_out}, 2'b11);
        @(posedge clk_in); #2 rst_n_in = 1'b1;
        @(posedge clk_in); #1;

        // back-to-back multiplies
        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 32'h0000_0001, acc);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 32'h0000_0000, acc);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 32'hFFFF_FFFF, acc);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 32'hFFFF_FFFE, acc);
        drain();

        // iterative divides
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 4'd5, 32'hFFFF_FFFD, acc);
        drain();
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 4'd6, 32'hFFFF_FFFF, acc);
        drain();
        issue(3'd5, 32'd100, 32'd7, 4'd7, 32'd14, acc);
        for (int i = 0; i <= XLEN; i++) begin
            check("div_busy_ready", {mul_ready_out, div_ready_out}, 2'b00);
            @(posedge clk_in); #1;
        end
        check("div_free_ready", {mul_ready_out, div_ready_out}, 2'b11);
        drain();

        // fast-path divides
        issue(3'd5, 32'd5, 32'd0, 4'd8, 32'hFFFF_FFFF, acc); drain();
        issue(3'd7, 32'd5, 32'd0, 4'd9, 32'd5, acc); drain();
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd10, 32'h8000_0000, acc); drain();
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd11, 32'h0, acc); drain();

        // divide waits for the multiplier pipe to empty
        issue(3'd0, 32'd3, 32'd4, 4'd12, 32'd12, acc);
        check("div_blocked", div_ready_out, 0);
        issue(3'd5, 32'd20, 32'd3, 4'd13, 32'd6, acc2);
        check("div_wait", acc2 - acc, MUL_LAT + 1);
        drain();

        // flush mid-divide
        issue(3'd5, 32'd1000, 32'd9, 4'd14, 32'd111, acc);
        idle(10);
        flush();
        check("flush_div_ready", div_ready_out, 1);
        idle(XLEN + 5);

        // flush coinciding with a multiply completion
        issue(3'd0, 32'd9, 32'd9, 4'd15, 32'd81, acc);
        idle(MUL_LAT - 1);
        flush();
        check("flush_mul_done", done_result, 0);
        idle(5);

        // stall in the middle of a multiply
        issue(3'd0, 32'd6, 32'd7, 4'd9, 32'd42, acc);
        stall(5);
        drain();

        // asynchronous reset in the middle of a divide
        issue(3'd5, 32'd777, 32'd5, 4'd3, 32'd155, acc);
        idle(10);
        #2 rst_n_in = 1'b0;
        #1;
        check("arst_done", done_result, 0);
        check("arst_value", value_result, 0);
        check("arst_tag", tag_result, 0);
        check("arst_ready", {mul_ready_out, div_ready_out}, 2'b11);
        exp_q.delete();
        repeat (3) @(posedge clk_in);
        #2 rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        idle(XLEN + 5);

        // randomized traffic with occasional stalls
        for (int n = 0; n < 60; n++) begin
            op   = 3'($urandom_range(0, 7));
            mode = $urandom_range(0, 9);
            a    = $urandom;
            b    = $urandom;
            if (mode == 0) b = 32'h0;
            else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (mode < 4) begin a = 32'($urandom_range(0, 300)) - 32'd150; b = 32'($urandom_range(1, 20)); end
            t = 4'($urandom);
            issue(op, a, b, t, ref_val(op, a, b), acc);
            if ($urandom_range(0, 9) == 0) stall($urandom_range(1, 3));
            else idle($urandom_range(0, 2));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised multiply/divide execution unit for the RV32M extension; sits beside the integer ALU.
- Takes operands and a ROB tag from the reservation station and broadcasts the result with the tag to RS, LSB and ROB.
- The integer ALU is a single-cycle unit; this unit adds multi-cycle timing:
  - a pipelined multiplier of configurable latency;
  - an iterative radix-2 divider driven by a state machine;
  - operation-specific ready handshakes;
  - speculative-flush support.

Parameters:
- XLEN, 32, operand and result width.
- ROB_WIDTH, 4, width of the ROB tag.
- MUL_LAT, 2, multiplier pipeline depth in cycles; legal range 1..4.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- rdy_in  input  1  global ready; when low, the unit freezes.
- clear_signal  input  1  misprediction flush.
- cal_signal  input  1  issue strobe from the RS.
- opcode  input  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- lhs  input  XLEN  operand rs1.
- rhs  input  XLEN  operand rs2.
- tag  input  ROB_WIDTH  ROB tag of the issued instruction.
- mul_ready_out  output  1  unit can accept opcodes 0-3 this cycle.
- div_ready_out  output  1  unit can accept opcodes 4-7 this cycle.
- done_result  output  1  one-cycle result-valid pulse.
- value_result  output  XLEN  result value.
- tag_result  output  ROB_WIDTH  ROB tag of the result.

Behaviour:
- Reset (asynchronous, rst_n_in low):
  - done_result, value_result and tag_result go to 0 immediately.
  - All multiplier pipeline valid bits clear.
  - Divider FSM goes to IDLE.
  - Both ready outputs read 1 after reset.
- Accept condition: rdy_in & ~clear_signal & cal_signal & the matching ready (opcode[2]=0 uses mul_ready_out; opcode[2]=1 uses div_ready_out).
  - cal_signal while the matching ready is low is a protocol violation. The unit ignores it, and the bench flags it with an assertion.
- mul_ready_out = (divider FSM == IDLE).
- div_ready_out = (divider FSM == IDLE) & no valid entry in the multiplier pipeline. This guarantees the two paths never complete in the same cycle.
- Multiply path:
  - Fully pipelined; one accept per cycle is allowed.
  - An accept at edge k gives done_result=1 after edge k+MUL_LAT; results leave in issue order.
  - The product is 2*XLEN bits wide.
  - Operand signedness:
    - MUL: either signedness; result is the low XLEN bits.
    - MULH: signed x signed.
    - MULHSU: signed lhs x unsigned rhs.
    - MULHU: unsigned x unsigned.
  - MULH, MULHSU and MULHU return the high XLEN bits.
- Divider FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on a div accept with a normal case.
    - The unit latches the operand magnitudes, the result sign, the tag and the op.
    - The iteration counter loads XLEN.
  - RUN: one restoring shift-subtract step per cycle; the counter decrements. When the counter reaches 0, go to DONE.
  - DONE: apply the signs.
    - Quotient is negative iff the signed operation has operands of differing sign.
    - Remainder takes the sign of the dividend.
    - Drive the result with done_result=1; go to IDLE.
  - Normal-case latency: accept at edge k gives done_result after edge k+XLEN+1.
- Divider fast path (IDLE -> DONE, done_result after edge k+1):
  - rhs == 0: DIV and DIVU return all ones; REM and REMU return lhs.
  - Signed overflow (lhs = 1 followed by XLEN-1 zeros, rhs = all ones): DIV returns lhs; REM returns 0.
- Output registers:
  - done_result is high for exactly one rdy_in-qualified cycle per accepted op. In every other cycle with rdy_in=1 it returns to 0.
  - value_result and tag_result hold their last value when done_result=0.
- rdy_in low: every register holds its value, including done_result, the pipeline, the FSM and the counter. Timing resumes unchanged when rdy_in returns high.
- Flush (clear_signal & rdy_in) at an edge:
  - Clear done_result and all pipeline valid bits.
  - Force the FSM to IDLE.
  - Accept nothing in that cycle.
  - No result from before the flush may ever appear afterwards.
- A flush coinciding with a result completion discards that result.
- A reset asserted mid-operation discards all in-flight work.

Test Plan:
- MUL_LAT=2: issue four back-to-back ops, all with lhs=rhs=0xFFFFFFFF, with tags 1-4 (MUL, MULH, MULHSU, MULHU) -> done_result pulses on 4 consecutive cycles, starting 2 cycles after the first accept, with values 0x00000001, 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE and tags 1-4.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14, with done 33 cycles after accept and div_ready_out and mul_ready_out low in between.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0. Each completes 1 cycle after accept.
- Issue MUL, then DIV on the next cycle -> the DIV is not accepted (div_ready_out=0) until the MUL result has left the pipeline.
- Accept DIVU, assert clear_signal 10 cycles later -> done_result never rises for that tag, and div_ready_out=1 on the cycle after the flush. Repeat with a flush in a cycle where a MUL result completes -> no pulse.
- Hold rdy_in low for 5 cycles mid-MUL -> the result arrives 5 cycles late with the correct value and tag. Drop rst_n_in asynchronously mid-DIV -> done_result is 0 immediately, and no stale result appears after release.
